// File: rtl/ps2_keyboard_pkg.sv
// Shared scan-code constants, state encodings and event bundle
// for the PS/2 Set-2 keyboard sequencer.
package ps2_keyboard_pkg;

  localparam logic [7:0] SC_E0 = 8'hE0;
  localparam logic [7:0] SC_F0 = 8'hF0;
  localparam logic [7:0] SC_E1 = 8'hE1;
  localparam logic [7:0] SC_AA = 8'hAA;
  localparam logic [7:0] SC_FA = 8'hFA;
  localparam logic [7:0] SC_EE = 8'hEE;
  localparam logic [7:0] SC_FE = 8'hFE;
  localparam logic [7:0] SC_FC = 8'hFC;
  localparam logic [7:0] SC_00 = 8'h00;
  localparam logic [7:0] SC_FF = 8'hFF;
  localparam logic [7:0] SC_12 = 8'h12;
  localparam logic [7:0] SC_59 = 8'h59;
  localparam logic [7:0] SC_77 = 8'h77;

  localparam int PAUSE_LEN = 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EXT     = 3'd1,
    S_BRK     = 3'd2,
    S_EXT_BRK = 3'd3,
    S_PAUSE   = 3'd4
  } state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       rel;
  } key_evt_t;

  function automatic logic is_err(
    input logic [7:0] b
  );
    return (b == SC_00) || (b == SC_FF);
  endfunction

  function automatic logic is_fake(
    input logic [7:0] b
  );
    return (b == SC_12) || (b == SC_59);
  endfunction

endpackage

// File: rtl/ps2_timeout.sv
// Inter-byte watchdog: counts idle cycles while enabled and
// raises a one-cycle expired strobe at TIMEOUT-1.
module ps2_timeout #(
  parameter int TIMEOUT = 1_000_000
) (
  input  logic clk,
  input  logic reset_low,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] cnt;

  assign expired = enable && !clear &&
                   (cnt == CW'(TIMEOUT - 1));

  // Idle-cycle counter, restarted by bytes, idle and expiry
  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      cnt <= '0;
    end else if (clear || !enable || expired) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/ps2_keyboard.sv
// Set-2 scan-code sequencer: folds E0/F0/E1 prefixes into
// single key events and filters controller bytes.
module ps2_keyboard
  import ps2_keyboard_pkg::*;
#(
  parameter int TIMEOUT = 1_000_000
) (
  input  logic       clk,
  input  logic       reset_low,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  output logic       key_valid,
  input  logic       key_ready,
  output logic [7:0] key_code,
  output logic       key_extended,
  output logic       key_release,
  output logic       bat_ok,
  output logic       kbd_error
);

  state_t   state, state_n;
  logic [2:0] skip, skip_n;
  key_evt_t evt_n;
  logic     emit, bat_n, err_n;
  logic     accept, busy, expired;

  assign byte_ready = !key_valid;
  assign accept     = byte_valid && byte_ready;
  assign busy       = (state != S_IDLE);

  ps2_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .reset_low(reset_low),
    .clear    (accept),
    .enable   (busy),
    .expired  (expired)
  );

  // Next-state, skip count and event/pulse decode
  always_comb begin
    state_n = state;
    skip_n  = skip;
    evt_n   = '{code: byte_data, ext: 1'b0, rel: 1'b0};
    emit    = 1'b0;
    bat_n   = 1'b0;
    err_n   = 1'b0;
    if (accept) begin
      if (busy && is_err(byte_data)) begin
        state_n = S_IDLE;
        skip_n  = '0;
        err_n   = 1'b1;
      end else begin
        unique case (state)
          S_IDLE: begin
            unique case (1'b1)
              byte_data == SC_E0: state_n = S_EXT;
              byte_data == SC_F0: state_n = S_BRK;
              byte_data == SC_E1: begin
                state_n = S_PAUSE;
                skip_n  = 3'(PAUSE_LEN - 1);
              end
              byte_data == SC_AA: bat_n = 1'b1;
              byte_data == SC_FA ||
              byte_data == SC_EE ||
              byte_data == SC_FE: emit = 1'b0;
              byte_data == SC_00 ||
              byte_data == SC_FF ||
              byte_data == SC_FC: err_n = 1'b1;
              default: emit = 1'b1;
            endcase
          end
          S_EXT: begin
            unique case (1'b1)
              byte_data == SC_F0: state_n = S_EXT_BRK;
              is_fake(byte_data): state_n = S_IDLE;
              default: begin
                emit      = 1'b1;
                evt_n.ext = 1'b1;
                state_n   = S_IDLE;
              end
            endcase
          end
          S_BRK: begin
            emit      = 1'b1;
            evt_n.rel = 1'b1;
            state_n   = S_IDLE;
          end
          S_EXT_BRK: begin
            state_n = S_IDLE;
            if (!is_fake(byte_data)) begin
              emit      = 1'b1;
              evt_n.ext = 1'b1;
              evt_n.rel = 1'b1;
            end
          end
          S_PAUSE: begin
            skip_n = skip - 3'd1;
            if (skip_n == 3'd0) begin
              emit       = 1'b1;
              evt_n.code = SC_77;
              evt_n.ext  = 1'b1;
              state_n    = S_IDLE;
            end
          end
          default: state_n = S_IDLE;
        endcase
      end
    end else if (expired) begin
      state_n = S_IDLE;
      skip_n  = '0;
      err_n   = 1'b1;
    end
  end

  // Sequencer state and pause skip counter
  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      state <= S_IDLE;
      skip  <= '0;
    end else begin
      state <= state_n;
      skip  <= skip_n;
    end
  end

  // Registered event slot and status pulses
  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      key_valid    <= 1'b0;
      key_code     <= '0;
      key_extended <= 1'b0;
      key_release  <= 1'b0;
      bat_ok       <= 1'b0;
      kbd_error    <= 1'b0;
    end else begin
      bat_ok    <= bat_n;
      kbd_error <= err_n;
      if (emit) begin
        key_valid    <= 1'b1;
        key_code     <= evt_n.code;
        key_extended <= evt_n.ext;
        key_release  <= evt_n.rel;
      end else if (key_ready) begin
        key_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_keyboard.sv
// Randomized self-checking bench for ps2_keyboard against a
// sequence-level scan-code model.
module tb_ps2_keyboard;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset_low = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic       byte_ready;
  logic       key_valid;
  logic       key_ready = 1'b1;
  logic [7:0] key_code;
  logic       key_extended;
  logic       key_release;
  logic       bat_ok;
  logic       kbd_error;

  ps2_keyboard #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset_low   (reset_low),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .byte_ready  (byte_ready),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .key_code    (key_code),
    .key_extended(key_extended),
    .key_release (key_release),
    .bat_ok      (bat_ok),
    .kbd_error   (kbd_error)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: bytes of the open sequence kept as a list
  logic [7:0] pend[$];
  logic [9:0] exp_q[$];
  int exp_bat = 0, exp_err = 0;
  int seen_bat = 0, seen_err = 0;

  function automatic void mdl(input logic [7:0] b);
    logic ext, rel;
    if (pend.size() == 0) begin
      if (b == 8'hE0 || b == 8'hF0 || b == 8'hE1)
        pend.push_back(b);
      else if (b == 8'hAA)
        exp_bat++;
      else if (b == 8'hFA || b == 8'hEE || b == 8'hFE)
        ext = 1'b0;
      else if (b == 8'h00 || b == 8'hFF || b == 8'hFC)
        exp_err++;
      else
        exp_q.push_back({b, 2'b00});
    end else if (b == 8'h00 || b == 8'hFF) begin
      exp_err++;
      pend.delete();
    end else if (pend[0] == 8'hE1) begin
      pend.push_back(b);
      if (pend.size() == 8) begin
        exp_q.push_back({8'h77, 2'b10});
        pend.delete();
      end
    end else if (pend.size() == 1 && pend[0] == 8'hE0 &&
                 b == 8'hF0) begin
      pend.push_back(b);
    end else begin
      ext = (pend[0] == 8'hE0);
      rel = (pend[pend.size()-1] == 8'hF0);
      if (!(ext && (b == 8'h12 || b == 8'h59)))
        exp_q.push_back({b, ext, rel});
      pend.delete();
    end
  endfunction

  // Monitor: events at handshake, pulse counts, hold stability
  logic       held = 1'b0;
  logic [9:0] held_v;
  always @(negedge clk) begin
    if (reset_low) begin
      if (bat_ok) seen_bat++;
      if (kbd_error) seen_err++;
      if (held && key_valid)
        check("hold", {22'd0, key_code, key_extended, key_release},
              {22'd0, held_v});
      if (key_valid && key_ready) begin
        if (exp_q.size() == 0)
          check("evt_extra", exp_q.size(), 1);
        else
          check("evt", {22'd0, key_code, key_extended, key_release},
                {22'd0, exp_q.pop_front()});
      end
      held = key_valid && !key_ready;
      held_v = {key_code, key_extended, key_release};
    end else begin
      held = 1'b0;
    end
  end

  logic rnd_en = 1'b0;
  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_en) key_ready = ($urandom_range(0, 3) != 0);
  end

  // Present one byte; returns at posedge+1 after acceptance
  task automatic send(input logic [7:0] b, input int gap);
    int n = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    forever begin
      @(negedge clk);
      if (byte_ready) break;
      n++;
      if (n > 200) break;
    end
    if (n > 200) begin
      check("accept_stall", n, 0);
    end else begin
      mdl(b);
    end
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    repeat (gap) @(posedge clk);
    if (gap > 0) #1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check({"drain_", tag}, exp_q.size(), 0);
    check({"bat_", tag}, seen_bat, exp_bat);
    check({"err_", tag}, seen_err, exp_err);
  endtask

  function automatic logic is_special(input logic [7:0] b);
    return b inside {8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'hFA, 8'hEE,
                     8'hFE, 8'h00, 8'hFF, 8'hFC};
  endfunction

  function automatic logic [7:0] rkey();
    logic [7:0] b;
    do b = 8'($urandom_range(1, 254)); while (is_special(b));
    return b;
  endfunction

  task automatic rand_token();
    logic [7:0] ctl[7];
    int g;
    ctl = '{8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF, 8'hFC};
    g = $urandom_range(0, 4);
    case ($urandom_range(0, 9))
      0, 1, 2: send(rkey(), g);
      3: begin send(8'hF0, g); send(rkey(), g); end
      4: begin send(8'hE0, g); send(rkey(), g); end
      5: begin
        send(8'hE0, g); send(8'hF0, g); send(rkey(), g);
      end
      6: begin
        send(8'hE0, g);
        if ($urandom_range(0, 1) != 0) send(8'hF0, g);
        send(($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59, g);
      end
      7: begin
        send(8'hE1, g); send(8'h14, g); send(8'h77, g);
        send(8'hE1, g); send(8'hF0, g); send(8'h14, g);
        send(8'hF0, g); send(8'h77, g);
      end
      8: send(ctl[$urandom_range(0, 6)], g);
      default: begin
        case ($urandom_range(0, 2))
          0: send(8'hE0, g);
          1: send(8'hF0, g);
          default: begin send(8'hE1, g); send(8'h14, g); end
        endcase
        send(($urandom_range(0, 1) != 0) ? 8'h00 : 8'hFF, g);
      end
    endcase
  endtask

  initial begin
    #12;
    check("rst_out", {26'd0, key_valid, key_extended, key_release,
                      bat_ok, kbd_error, 1'b0} | {24'd0, key_code},
          32'd0);
    check("rst_brdy", byte_ready, 1);
    @(negedge clk);
    reset_low = 1'b1;
    @(posedge clk);
    #1;

    send(8'h1C, 0);
    check("lat_plain", key_valid, 1);
    send(8'hF0, 0); send(8'h1C, 0);
    drain("plain");

    send(8'hE0, 0); send(8'h75, 0);
    send(8'hE0, 0); send(8'hF0, 0); send(8'h75, 0);
    send(8'hE0, 0); send(8'h12, 0);
    send(8'hE0, 0); send(8'hF0, 0); send(8'h12, 0);
    drain("ext");

    send(8'hE1, 0); send(8'h14, 0); send(8'h77, 0);
    send(8'hE1, 0); send(8'hF0, 0); send(8'h14, 0);
    send(8'hF0, 0);
    check("pause_early", key_valid, 0);
    send(8'h77, 0);
    check("pause_lat", key_valid, 1);
    drain("pause");

    key_ready = 1'b0;
    send(8'h1C, 0);
    byte_valid = 1'b1;
    byte_data  = 8'h32;
    repeat (3) @(posedge clk);
    #1;
    check("bp_brdy", byte_ready, 0);
    check("bp_code", key_code, 8'h1C);
    key_ready = 1'b1;
    send(8'h32, 0);
    drain("bp");

    send(8'hAA, 0); send(8'hFA, 0); send(8'hFF, 0);
    drain("ctl");

    send(8'hE0, 0);
    repeat (15) @(posedge clk);
    #1;
    check("to_early", kbd_error, 0);
    @(posedge clk);
    #1;
    check("to_pulse", kbd_error, 1);
    exp_err++;
    pend.delete();
    send(8'h1C, 2);
    drain("timeout");

    send(8'hE0, 0); send(8'hF0, 0);
    #2;
    reset_low = 1'b0;
    #1;
    check("mid_rst", {24'd0, key_code} |
          {27'd0, key_valid, key_extended, key_release, bat_ok,
           kbd_error}, 0);
    check("mid_brdy", byte_ready, 1);
    pend.delete();
    @(negedge clk);
    reset_low = 1'b1;
    @(posedge clk);
    #1;
    send(8'h1C, 0);
    drain("reset");

    rnd_en = 1'b1;
    for (int i = 0; i < 300; i++) rand_token();
    rnd_en = 1'b0;
    @(posedge clk);
    #1;
    key_ready = 1'b1;
    repeat (TO + 2) @(posedge clk);
    if (pend.size() != 0) begin
      exp_err++;
      pend.delete();
    end
    drain("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
